seven_seg_decoder: RTL and testbench
====================================

# seven_seg_decoder

- Recovers a hex nibble from an active-low 7-segment line pattern, the inverse of the board's hex-to-7-segment encoding.
- Sits between a sampled display bus (loop-back checker, or a captured HEX0–HEX5 line from a neighbouring board) and downstream logic.
- A pattern is reported only after it has been stable for a programmable number of cycles. Each new stable pattern is reported once over a valid/ready handshake.
- Illegal stable patterns raise a one-cycle error pulse.

## Interface
- STABLE_CYCLES, default 4: consecutive identical registered samples required to qualify a pattern; legal range 2..255.
- i_clk  input  1  sole clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_display  input  7  segment lines, active-low, bit 0 = segment a … bit 6 = segment g; synchronous to i_clk.
- i_ready  input  1  consumer accepts o_number when high together with o_valid.
- o_number  output  4  decoded hex value; stable while o_valid is high.
- o_valid  output  1  decoded value available.
- o_badPattern  output  1  one-cycle pulse when a qualified pattern is not a legal code.

## Operation
- Legal codes, value:pattern(g..a):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0011000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Blank is 1111111. It is neither legal nor an error.
- Input stage: i_display is registered every cycle into r_sample.
- Stability counter r_count, 8 bits:
  - Cleared when i_display ≠ r_sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- A pattern qualifies on the cycle r_count reaches STABLE_CYCLES.
- r_lastPattern holds the last qualified pattern; it resets to blank.
- On qualification, if the pattern equals r_lastPattern, nothing happens.
- Otherwise r_lastPattern is updated and the action depends on the pattern:
  - Blank: no output. Because r_lastPattern becomes blank, a digit that reappears after a blank is reported again.
  - Legal code: the decoded value is loaded and o_valid is raised.
  - Illegal code: o_badPattern pulses for one cycle; o_valid is not raised.
- FSM states:
  - TRACK: counting and qualifying. Goes to PRESENT on a legal new pattern.
  - PRESENT: o_valid high and o_number held. Goes to TRACK on the cycle i_valid&i_ready is sampled, i.e. o_valid&i_ready.
- In PRESENT, the counter keeps running, but qualification is deferred. Only the most recent qualified pattern is evaluated on return to TRACK; intermediate patterns are dropped and no queue is kept.
- Reset mid-operation: FSM returns to TRACK, counter is cleared, r_lastPattern becomes blank. Any pending value is discarded without handshake.

## Timing
- Reset values:
  - o_number = 0, o_valid = 0, o_badPattern = 0.
  - r_sample = blank, r_count = 0.
- Latency: pattern applied before edge 0 and held stable → o_valid (or o_badPattern) high after edge STABLE_CYCLES+1.
- o_valid falls on the edge that samples i_ready = 1. Same-cycle acceptance means one transfer per handshake.
- i_ready high while o_valid is low has no effect.
- o_valid never drops without acceptance. o_number does not change while o_valid is high.
- Earliest re-qualification after acceptance: the edge after the handshake, if a new pattern is already stable.
- Glitches shorter than STABLE_CYCLES+1 cycles never produce output.
- Saturation: r_count does not wrap for patterns held indefinitely.

## Structure
- Shared package sevenSegPkg holds:
  - the 16-entry legal pattern constant array;
  - the BLANK constant 7'h7F;
  - the FSM state enum.
  - The existing encoder should migrate to this package too.
- The decoder is built around one combinational sub-module, sevenSegLookup: pattern in; nibble, legal and blank flags out.
- The top level holds the register stage, counter, FSM and handshake.

## Test plan
- STABLE_CYCLES=4; hold 0010010 with i_ready=1 → o_valid high after edge 5, o_number=5, low the next cycle; no further report while the pattern is held.
- Toggle i_display between 1111001 and 0100100 every 3 cycles for 30 cycles → o_valid and o_badPattern stay 0.
- Hold 1111111, then 0101010 → no output for blank; o_badPattern one-cycle pulse at edge 5 of the illegal pattern; o_valid stays 0.
- i_ready=0; qualify 3 (0110000), then change the input to 0000110 → o_valid and o_number=3 held. Raise i_ready → handshake, then o_valid with o_number=E one edge later.
- Sequence 8 → blank → 8, each held 6 cycles, i_ready=1 → two reports of 8.
- Assert i_rst while o_valid=1 → o_valid=0 immediately (asynchronous). After release, the same held pattern is re-reported after STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/seven_seg_decoder_pkg.sv
// Shared 7-segment definitions: legal active-low segment codes (bit 0 = a .. bit 6 = g),
// the blank pattern, the decoder FSM state type and the hex-to-segment encoder helper.
package seven_seg_decoder_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned NUM_CODES = 16;
    localparam int unsigned CNT_W     = 8;

    // All segments off.
    localparam logic [SEG_W-1:0] BLANK = 7'h7F;

    // Index = hex value, entry = active-low pattern g..a.
    localparam logic [SEG_W-1:0] SEG_CODES [NUM_CODES] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [0:0] {
        ST_TRACK   = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    // Forward encoding, shared with the board's hex display driver.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble);
        return SEG_CODES[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_decoder_lookup.sv
// Combinational inverse of the segment encoding.
//   i_pattern : active-low segment pattern
//   o_nibble  : decoded value (0 when not legal)
//   o_legal   : pattern is one of the 16 legal codes
//   o_blank   : pattern is all segments off
module seven_seg_decoder_lookup
    import seven_seg_decoder_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output logic [NIB_W-1:0] o_nibble,
    output logic             o_legal,
    output logic             o_blank
);

    // Codes are unique, so at most one entry matches.
    always_comb begin
        o_nibble = '0;
        o_legal  = 1'b0;
        for (int unsigned i = 0; i < NUM_CODES; i++) begin
            if (i_pattern == SEG_CODES[i]) begin
                o_nibble = NIB_W'(i);
                o_legal  = 1'b1;
            end
        end
    end

    assign o_blank = (i_pattern == BLANK);

endmodule

// File: rtl/seven_seg_decoder.sv
// Recovers a hex nibble from a sampled active-low 7-segment bus. A pattern must be held
// for STABLE_CYCLES consecutive registered samples before it is evaluated; each new legal
// pattern is reported once over valid/ready, each new illegal one pulses o_badPattern.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_display     : segment lines, active-low, bit 0 = a .. bit 6 = g
//   i_ready       : consumer accepts o_number when high with o_valid
//   o_number      : decoded value, held while o_valid
//   o_valid       : decoded value available
//   o_badPattern  : one-cycle pulse for a qualified illegal pattern
module seven_seg_decoder
    import seven_seg_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SEG_W-1:0] i_display,
    input  logic             i_ready,
    output logic [NIB_W-1:0] o_number,
    output logic             o_valid,
    output logic             o_badPattern
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    state_e           state_q,  state_d;
    logic [SEG_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [SEG_W-1:0] qual_q,   qual_d;
    logic [SEG_W-1:0] last_q,   last_d;
    logic [NIB_W-1:0] number_q, number_d;
    logic             valid_q,  valid_d;
    logic             bad_q,    bad_d;

    logic [NIB_W-1:0] lk_nibble;
    logic             lk_legal;
    logic             lk_blank;

    // qual_d is the most recent qualified pattern, including one that qualified while
    // presenting and has since disappeared from the bus.
    seven_seg_decoder_lookup u_lookup (
        .i_pattern (qual_d),
        .o_nibble  (lk_nibble),
        .o_legal   (lk_legal),
        .o_blank   (lk_blank)
    );

    // Input register and saturating stability counter.
    always_comb begin
        sample_d = i_display;
        if (i_display != sample_q) begin
            count_d = '0;
        end else if (count_q == STABLE_CNT) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
        qual_d = (count_q == STABLE_CNT) ? sample_q : qual_q;
    end

    // Qualification and handshake FSM; evaluation is deferred while presenting.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        number_d = number_q;
        valid_d  = valid_q;
        bad_d    = 1'b0;
        unique case (state_q)
            ST_TRACK: begin
                if (qual_d != last_q) begin
                    last_d = qual_d;
                    if (lk_legal) begin
                        number_d = lk_nibble;
                        valid_d  = 1'b1;
                        state_d  = ST_PRESENT;
                    end else if (!lk_blank) begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_TRACK;
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_TRACK;
            sample_q <= BLANK;
            count_q  <= '0;
            qual_q   <= BLANK;
            last_q   <= BLANK;
            number_q <= '0;
            valid_q  <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            count_q  <= count_d;
            qual_q   <= qual_d;
            last_q   <= last_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            bad_q    <= bad_d;
        end
    end

    assign o_number     = number_q;
    assign o_valid      = valid_q;
    assign o_badPattern = bad_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Scenario bench for seven_seg_decoder (STABLE_CYCLES = 4). Expected reports are queued
// when stimulus is applied and popped when the DUT presents a new value or error pulse.
module tb_seven_seg_decoder;

    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_1     = 7'b1111001;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_3     = 7'b0110000;
    localparam logic [6:0] P_5     = 7'b0010010;
    localparam logic [6:0] P_8     = 7'b0000000;
    localparam logic [6:0] P_E     = 7'b0000110;
    localparam logic [6:0] P_ILL   = 7'b0101010;
    localparam int         EXP_BAD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] display = P_BLANK;
    logic       ready = 1'b0;
    logic [3:0] number;
    logic       valid;
    logic       bad_pattern;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    seven_seg_decoder #(.STABLE_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_display    (display),
        .i_ready      (ready),
        .o_number     (number),
        .o_valid      (valid),
        .o_badPattern (bad_pattern)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs observed 1 time unit after it. Checks held values while
    // back-pressured and pops the scoreboard on every new report or error pulse.
    task automatic step();
        logic       vb;
        logic       rb;
        logic [3:0] nb;
        int         e;
        vb = valid;
        rb = ready;
        nb = number;
        @(posedge clk);
        #1;
        if (vb === 1'b1 && rb !== 1'b1) begin
            total++;
            if (valid !== 1'b1 || number !== nb) begin
                bad++;
                $display("FAIL hold: valid=%b number=%h, required valid=1 number=%h", valid, number, nb);
            end
        end else if (valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_report: number=%h, required no report", number);
            end else begin
                e = exp_q.pop_front();
                if (e !== int'(number)) begin
                    bad++;
                    $display("FAIL report: number=%0d, required code %0d", number, e);
                end
            end
        end
        if (bad_pattern === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bad: badPattern=1, required 0");
            end else begin
                e = exp_q.pop_front();
                if (e !== EXP_BAD) begin
                    bad++;
                    $display("FAIL bad_pulse: got badPattern, required code %0d", e);
                end
            end
        end
    endtask

    // Reset with a blank bus; the next posedge after return is edge 0.
    task automatic apply_reset();
        rst     = 1'b1;
        display = P_BLANK;
        ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d reports outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || bad_pattern !== 1'b0 || number !== 4'h0) begin
            bad++;
            $display("FAIL reset_async: valid=%b bad=%b number=%h, required 0 0 0", valid, bad_pattern, number);
        end
        display = P_5;
        @(posedge clk);
        #1;
        total++;
        if (valid !== 1'b0 || bad_pattern !== 1'b0 || number !== 4'h0) begin
            bad++;
            $display("FAIL reset_held: valid=%b bad=%b number=%h, required 0 0 0", valid, bad_pattern, number);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        ready   = 1'b1;
        display = P_5;
        exp_q.push_back(5);
        for (int e = 0; e < 14; e++) begin
            step();
            total++;
            if (valid !== 1'(e == 5)) begin
                bad++;
                $display("FAIL single_valid: edge %0d valid=%b, required %b", e, valid, 1'(e == 5));
            end
        end
        check_drained("single");
    endtask

    task automatic test_glitch();
        apply_reset();
        ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            display = ((c / 3) % 2 == 0) ? P_1 : P_2;
            step();
            total++;
            if (valid !== 1'b0 || bad_pattern !== 1'b0) begin
                bad++;
                $display("FAIL glitch: cycle %0d valid=%b bad=%b, required 0 0", c, valid, bad_pattern);
            end
        end
    endtask

    task automatic test_blank_illegal();
        apply_reset();
        ready = 1'b1;
        repeat (10) step();
        display = P_ILL;
        exp_q.push_back(EXP_BAD);
        for (int e = 0; e < 12; e++) begin
            step();
            total++;
            if (bad_pattern !== 1'(e == 5) || valid !== 1'b0) begin
                bad++;
                $display("FAIL illegal: edge %0d bad=%b valid=%b, required %b 0", e, bad_pattern, valid, 1'(e == 5));
            end
        end
        check_drained("illegal");
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready   = 1'b0;
        display = P_3;
        exp_q.push_back(3);
        for (int e = 0; e < 8; e++) step();
        display = P_E;
        exp_q.push_back(14);
        for (int e = 8; e < 20; e++) step();
        total++;
        if (valid !== 1'b1 || number !== 4'h3) begin
            bad++;
            $display("FAIL bp_held: valid=%b number=%h, required 1 3", valid, number);
        end
        ready = 1'b1;
        step();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: valid=%b, required 0", valid);
        end
        step();
        total++;
        if (valid !== 1'b1 || number !== 4'hE) begin
            bad++;
            $display("FAIL bp_next: valid=%b number=%h, required 1 e", valid, number);
        end
        repeat (6) step();
        check_drained("backpressure");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ready = 1'b1;
        exp_q.push_back(8);
        exp_q.push_back(8);
        display = P_8;
        repeat (6) step();
        display = P_BLANK;
        repeat (6) step();
        display = P_8;
        repeat (6) step();
        repeat (6) step();
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ready   = 1'b0;
        display = P_5;
        exp_q.push_back(5);
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || number !== 4'h0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b number=%h, required 0 0", valid, number);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        exp_q.push_back(5);
        for (int e = 0; e < 10; e++) begin
            step();
            total++;
            if (valid !== 1'(e == 5)) begin
                bad++;
                $display("FAIL rereport: edge %0d valid=%b, required %b", e, valid, 1'(e == 5));
            end
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_blank_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
